// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch/PC control stage.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_DONE} fetch_state_t;

  localparam int unsigned PC_RESET = 0;

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Branch target table: async clear, synchronous write, combinational read.
module branch_lut #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle write and read of one entry returns the old contents.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter, branch select, start/stall/halt sequencing and RUN cycle counter.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned LUT_AW = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              BranchEn,
  input  logic [LUT_AW-1:0] Target,
  input  logic              CondFlag,
  input  logic              Halt,
  input  logic              Stall,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutData,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Running,
  output logic              Done,
  output logic [CNT_W-1:0]  CycleCnt
);

  fetch_state_t    state;
  logic [PC_W-1:0] lut_target;

  branch_lut #(
    .AW(LUT_AW),
    .DW(PC_W)
  ) u_lut (
    .clk  (Clk),
    .rst_n(Reset),
    .we   (LutWe),
    .waddr(LutAddr),
    .wdata(LutData),
    .raddr(Target),
    .rdata(lut_target)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= FS_IDLE;
      ProgCtr  <= PC_W'(PC_RESET);
      CycleCnt <= '0;
      Running  <= 1'b0;
      Done     <= 1'b0;
    end else if (Start) begin
      state    <= FS_RUN;
      ProgCtr  <= PC_W'(PC_RESET);
      CycleCnt <= '0;
      Running  <= 1'b1;
      Done     <= 1'b0;
    end else begin
      case (state)
        FS_RUN: begin
          // Counts every RUN edge, including stalls and the halting edge.
          if (CycleCnt != '1) CycleCnt <= CycleCnt + CNT_W'(1);
          if (Halt) begin
            state   <= FS_DONE;
            Running <= 1'b0;
            Done    <= 1'b1;
          end else if (Stall) begin
            ProgCtr <= ProgCtr;
          end else if (BranchEn && CondFlag) begin
            ProgCtr <= lut_target;
          end else begin
            ProgCtr <= ProgCtr + PC_W'(1);
          end
        end
        default: begin
          state   <= state;
          ProgCtr <= ProgCtr;
        end
      endcase
    end
  end

endmodule
